fetch_ctrl: RTL and testbench

- Sequences the instruction memory: owns the program counter, drives the IM byte address, and registers the returned word into the IF/ID stage with a valid/ready handshake.
- Handles branch redirect and flush, decode back-pressure, and out-of-range or misaligned fetch detection.
- Sits between the IM (combinational ROM, 16-bit byte address in, 32-bit word out) and the decode stage.

---
 rtl/fetch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the IM address and registers
// fetched words into IF/ID. Optional perf counters are enabled by FETCH_PERF_EN.
module fetch_ctrl #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int          IM_BYTES  = 128,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] im_addr,
   input  logic [31:0] im_instr,
   input  logic        br_taken,
   input  logic [15:0] br_target,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [15:0] if_pc,
   output logic        fetch_err,
   output logic        halted
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
`endif
);

   typedef enum logic [1:0] {
      BOOT = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } state_t;

   localparam logic [15:0] LAST_PC = 16'(IM_BYTES - 4);

   state_t      state_r, state_s;
   logic [15:0] pc_r, pc_s;
   logic        valid_s;
   logic [31:0] instr_s;
   logic [15:0] ifpc_s;
   logic        err_s;
   logic        halted_s;
   logic        stall_s;
   logic        xfer_s;

   // A PC is fetchable when word aligned and inside the IM window (unsigned compare)
   function automatic logic legal_pc(input logic [15:0] a);
      return (a[1:0] == 2'b00) && (a <= LAST_PC);
   endfunction

   assign im_addr = pc_r;
   assign stall_s = if_valid & ~id_ready;
   assign xfer_s  = if_valid & id_ready;

   // Next-state and next-output decode; branch beats stall beats disable beats fetch
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      valid_s = if_valid;
      instr_s = if_instr;
      ifpc_s  = if_pc;
      err_s   = fetch_err;
      case (state_r)
         BOOT: begin
            state_s = RUN;
         end
         RUN: begin
            if (br_taken) begin
               pc_s    = br_target;
               valid_s = 1'b0;
               instr_s = NOP_INSTR;
               if (!legal_pc(br_target)) begin
                  err_s   = 1'b1;
                  state_s = HALT;
               end else begin
                  err_s   = fetch_err;
               end
            end else if (stall_s) begin
               pc_s = pc_r;
            end else if (!en) begin
               if (id_ready) begin
                  valid_s = 1'b0;
               end else begin
                  valid_s = if_valid;
               end
            end else begin
               if (pc_r > LAST_PC) begin
                  err_s   = 1'b1;
                  valid_s = 1'b0;
                  state_s = HALT;
               end else begin
                  instr_s = im_instr;
                  ifpc_s  = pc_r;
                  valid_s = 1'b1;
                  pc_s    = pc_r + 16'd4;
               end
            end
         end
         HALT: begin
            valid_s = 1'b0;
            if (br_taken) begin
               // an illegal target leaves the PC where it was
               if (legal_pc(br_target)) begin
                  pc_s    = br_target;
                  err_s   = 1'b0;
                  instr_s = NOP_INSTR;
                  state_s = RUN;
               end else begin
                  err_s   = 1'b1;
               end
            end else begin
               err_s = fetch_err;
            end
         end
         default: begin
            state_s = BOOT;
            valid_s = 1'b0;
         end
      endcase
      halted_s = (state_s == HALT);
   end

   // State, PC and IF/ID output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= BOOT;
         pc_r      <= RESET_PC;
         if_valid  <= 1'b0;
         if_instr  <= NOP_INSTR;
         if_pc     <= 16'h0000;
         fetch_err <= 1'b0;
         halted    <= 1'b0;
      end else begin
         state_r   <= state_s;
         pc_r      <= pc_s;
         if_valid  <= valid_s;
         if_instr  <= instr_s;
         if_pc     <= ifpc_s;
         fetch_err <= err_s;
         halted    <= halted_s;
      end
   end

`ifdef FETCH_PERF_EN
   // Saturating transfer and stall counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= 32'h0000_0000;
         perf_stall   <= 32'h0000_0000;
      end else begin
         if (xfer_s && (perf_fetched != 32'hFFFF_FFFF)) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (stall_s && (perf_stall != 32'hFFFF_FFFF)) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`else
   logic unused_s;
   assign unused_s = xfer_s;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a scoreboard of expected (pc, instr)
// transfers plus direct checks of PC, flush, halt and reset behaviour.
module tb_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        en;
   logic [15:0] im_addr;
   logic [31:0] im_instr;
   logic        br_taken;
   logic [15:0] br_target;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [15:0] if_pc;
   logic        fetch_err;
   logic        halted;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   logic [31:0] imem [0:31];
   logic [47:0] exp_q [$];
   int          chk_cnt_r;
   int          err_cnt_r;
   int          xfer_cnt_r;

   localparam logic [31:0] NOP = 32'h00000013;

   fetch_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .im_addr   (im_addr),
      .im_instr  (im_instr),
      .br_taken  (br_taken),
      .br_target (br_target),
      .id_ready  (id_ready),
      .if_valid  (if_valid),
      .if_instr  (if_instr),
      .if_pc     (if_pc),
      .fetch_err (fetch_err),
      .halted    (halted)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
`endif
   );

   // Combinational instruction ROM model
   assign im_instr = (im_addr < 16'd128) ? imem[im_addr[6:2]] : 32'hDEAD_BEEF;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt_r++;
      if (act !== exp) begin
         err_cnt_r++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   task automatic push_exp(input logic [15:0] pc);
      exp_q.push_back({pc, imem[pc[6:2]]});
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard: every handshake transfer must match the next expected word
   always @(negedge clk) begin
      if (!rst && if_valid && id_ready) begin
         xfer_cnt_r++;
         if (exp_q.size() == 0) begin
            check_eq("sb_unexpected_pc", {16'h0000, if_pc}, 32'hFFFF_FFFF);
         end else begin
            logic [47:0] e;
            e = exp_q.pop_front();
            check_eq("sb_pc", {16'h0000, if_pc}, {16'h0000, e[47:32]});
            check_eq("sb_instr", if_instr, e[31:0]);
         end
      end
   end

   initial begin
      chk_cnt_r  = 0;
      err_cnt_r  = 0;
      xfer_cnt_r = 0;
      for (int i = 0; i < 32; i++) imem[i] = 32'hA500_0000 | i;
      imem[0] = 32'h00300413;
      imem[1] = 32'h00000013;
      imem[2] = 32'h00340413;
      rst = 1'b1; en = 1'b1; br_taken = 1'b0; br_target = 16'h0000; id_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
      check_eq("rst_instr", if_instr, NOP);
      check_eq("rst_pc", {16'h0000, if_pc}, 32'd0);
      check_eq("rst_err", {31'd0, fetch_err}, 32'd0);
      check_eq("rst_halted", {31'd0, halted}, 32'd0);
      check_eq("rst_imaddr", {16'h0000, im_addr}, 32'd0);
      rst = 1'b0;

      // sequential run from reset
      push_exp(16'd0); push_exp(16'd4); push_exp(16'd8);
      cyc(1);
      check_eq("boot_valid", {31'd0, if_valid}, 32'd0);
      check_eq("boot_imaddr", {16'h0000, im_addr}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         check_eq("run_valid", {31'd0, if_valid}, 32'd1);
         check_eq("run_pc", {16'h0000, if_pc}, 32'(4 * k));
         check_eq("run_imaddr", {16'h0000, im_addr}, 32'(4 * k + 4));
      end

      // stall for three cycles while holding the word at 8
      id_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         check_eq("stall_pc", {16'h0000, if_pc}, 32'd8);
         check_eq("stall_instr", if_instr, 32'h00340413);
         check_eq("stall_imaddr", {16'h0000, im_addr}, 32'd12);
         check_eq("stall_valid", {31'd0, if_valid}, 32'd1);
      end
      id_ready = 1'b1;
      cyc(1);
      check_eq("resume_pc", {16'h0000, if_pc}, 32'd12);

      // redirect while stalled: the word at 12 is flushed
      id_ready = 1'b0; br_taken = 1'b1; br_target = 16'h0010;
      cyc(1);
      br_taken = 1'b0; id_ready = 1'b1;
      check_eq("br_valid", {31'd0, if_valid}, 32'd0);
      check_eq("br_instr", if_instr, NOP);
      check_eq("br_imaddr", {16'h0000, im_addr}, 32'h10);
      push_exp(16'h0010);
      cyc(1);
      check_eq("br_pc", {16'h0000, if_pc}, 32'h10);

      // misaligned redirect, coincident with the transfer of 0x10
      br_taken = 1'b1; br_target = 16'h0006;
      cyc(1);
      br_taken = 1'b0;
      check_eq("mis_err", {31'd0, fetch_err}, 32'd1);
      check_eq("mis_halted", {31'd0, halted}, 32'd1);
      check_eq("mis_valid", {31'd0, if_valid}, 32'd0);
      cyc(2);
      check_eq("halt_hold", {31'd0, halted}, 32'd1);
      check_eq("halt_valid", {31'd0, if_valid}, 32'd0);
      check_eq("halt_imaddr", {16'h0000, im_addr}, 32'd6);

      // recover to 0 then run off the end of the IM window
      br_taken = 1'b1; br_target = 16'h0000;
      cyc(1);
      br_taken = 1'b0;
      check_eq("rec_err", {31'd0, fetch_err}, 32'd0);
      check_eq("rec_halted", {31'd0, halted}, 32'd0);
      check_eq("rec_imaddr", {16'h0000, im_addr}, 32'd0);
      for (int a = 0; a < 128; a += 4) push_exp(16'(a));
      cyc(32);
      check_eq("oor_lastpc", {16'h0000, if_pc}, 32'd124);
      check_eq("oor_imaddr", {16'h0000, im_addr}, 32'd128);
      check_eq("oor_noerr", {31'd0, fetch_err}, 32'd0);
      cyc(1);
      check_eq("oor_err", {31'd0, fetch_err}, 32'd1);
      check_eq("oor_halted", {31'd0, halted}, 32'd1);
      check_eq("oor_valid", {31'd0, if_valid}, 32'd0);

      // fetch disable, then stall and async reset mid-stall
      br_taken = 1'b1; br_target = 16'h0000;
      cyc(1);
      br_taken = 1'b0; en = 1'b0;
      cyc(2);
      check_eq("dis_valid", {31'd0, if_valid}, 32'd0);
      check_eq("dis_imaddr", {16'h0000, im_addr}, 32'd0);
      en = 1'b1;
      cyc(1);
      id_ready = 1'b0;
      check_eq("en_pc", {16'h0000, if_pc}, 32'd0);
      check_eq("en_valid", {31'd0, if_valid}, 32'd1);
      cyc(2);
      check_eq("sb_left", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_PERF_EN
      check_eq("perf_fetched", perf_fetched, 32'(xfer_cnt_r));
`endif
      #2 rst = 1'b1;
      #1;
      check_eq("arst_valid", {31'd0, if_valid}, 32'd0);
      check_eq("arst_instr", if_instr, NOP);
      check_eq("arst_pc", {16'h0000, if_pc}, 32'd0);
      check_eq("arst_imaddr", {16'h0000, im_addr}, 32'd0);
      check_eq("arst_err", {31'd0, fetch_err}, 32'd0);
      check_eq("arst_halted", {31'd0, halted}, 32'd0);
`ifdef FETCH_PERF_EN
      check_eq("arst_perf_f", perf_fetched, 32'd0);
      check_eq("arst_perf_s", perf_stall, 32'd0);
`endif
      cyc(2);
      $display("CHECKS %0d ERRORS %0d", chk_cnt_r, err_cnt_r);
      $finish;
   end

endmodule
